// File: rtl/prog_loader.sv
// Boot-stage program loader: parses an A5/length/payload/checksum frame, writes the
// payload into byte-wide instruction memory and holds the core until the frame verifies.
module prog_loader #(
  parameter int ADDR_W  = 12,
  parameter int TIMEOUT = 1000000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              core_hold,
  output logic              done,
  output logic              err,
  output logic [1:0]        err_code
);
  localparam int              CNT_W     = $clog2(TIMEOUT + 1);
  localparam logic [7:0]      SYNC_BYTE = 8'hA5;
  localparam logic [16:0]     MAX_N     = 17'(2 ** (ADDR_W - 2));
  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_SYNC = 3'd0,
    S_LEN0 = 3'd1,
    S_LEN1 = 3'd2,
    S_DATA = 3'd3,
    S_CSUM = 3'd4,
    S_DONE = 3'd5,
    S_ERR  = 3'd6
  } state_t;

  function automatic logic [7:0] csum_add(input logic [7:0] acc, input logic [7:0] b);
    return acc + b;
  endfunction

  state_t              state_q, state_d;
  logic [7:0]          len_lo_q, len_lo_d;
  logic [ADDR_W-1:0]   last_q, last_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [7:0]          csum_q, csum_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [7:0]          mem_wdata_q, mem_wdata_d;
  logic                core_hold_q, core_hold_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic [1:0]          err_code_q, err_code_d;
  logic                accept_s;
  logic                counting_s;
  logic [15:0]         n_s;

  // A byte offered alongside start is refused so the abort wins cleanly.
  assign in_ready   = ~start & (state_q != S_DONE) & (state_q != S_ERR);
  assign accept_s   = in_valid & in_ready;
  assign counting_s = (state_q == S_LEN0) || (state_q == S_LEN1) ||
                      (state_q == S_DATA) || (state_q == S_CSUM);
  assign n_s        = {in_data, len_lo_q};

  // Next-state and next-output logic for the frame parser.
  always_comb begin
    state_d     = state_q;
    len_lo_d    = len_lo_q;
    last_d      = last_q;
    addr_d      = addr_q;
    csum_d      = csum_q;
    cnt_d       = cnt_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    core_hold_d = core_hold_q;
    done_d      = done_q;
    err_d       = err_q;
    err_code_d  = err_code_q;
    if (start) begin
      state_d     = S_SYNC;
      addr_d      = '0;
      csum_d      = 8'd0;
      cnt_d       = '0;
      core_hold_d = 1'b1;
      done_d      = 1'b0;
      err_d       = 1'b0;
      err_code_d  = 2'd0;
    end else begin
      case (state_q)
        S_SYNC: begin
          if (accept_s && (in_data == SYNC_BYTE)) begin
            state_d = S_LEN0;
          end else begin
            state_d = S_SYNC;
          end
        end
        S_LEN0: begin
          if (accept_s) begin
            len_lo_d = in_data;
            state_d  = S_LEN1;
          end else begin
            state_d  = S_LEN0;
          end
        end
        S_LEN1: begin
          if (accept_s) begin
            addr_d = '0;
            csum_d = 8'd0;
            last_d = ADDR_W'({n_s, 2'b00} - 18'd1);
            if ({1'b0, n_s} > MAX_N) begin
              state_d     = S_ERR;
              err_d       = 1'b1;
              err_code_d  = 2'd1;
              core_hold_d = 1'b1;
            end else if (n_s == 16'd0) begin
              state_d = S_CSUM;
            end else begin
              state_d = S_DATA;
            end
          end else begin
            state_d = S_LEN1;
          end
        end
        S_DATA: begin
          if (accept_s) begin
            mem_we_d    = 1'b1;
            mem_addr_d  = addr_q;
            mem_wdata_d = in_data;
            addr_d      = addr_q + ADDR_W'(1);
            csum_d      = csum_add(csum_q, in_data);
            if (addr_q == last_q) begin
              state_d = S_CSUM;
            end else begin
              state_d = S_DATA;
            end
          end else begin
            state_d = S_DATA;
          end
        end
        S_CSUM: begin
          if (accept_s) begin
            if (in_data == csum_q) begin
              state_d     = S_DONE;
              done_d      = 1'b1;
              core_hold_d = 1'b0;
            end else begin
              state_d     = S_ERR;
              err_d       = 1'b1;
              err_code_d  = 2'd2;
              core_hold_d = 1'b1;
            end
          end else begin
            state_d = S_CSUM;
          end
        end
        S_DONE:  state_d = S_DONE;
        S_ERR:   state_d = S_ERR;
        default: state_d = S_SYNC;
      endcase

      // Inter-byte idle watchdog; only runs while a frame is open.
      if (counting_s) begin
        if (accept_s) begin
          cnt_d = '0;
        end else if (cnt_q == TO_LAST) begin
          cnt_d       = '0;
          state_d     = S_ERR;
          err_d       = 1'b1;
          err_code_d  = 2'd3;
          core_hold_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end else begin
        cnt_d = '0;
      end
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= S_SYNC;
      len_lo_q    <= 8'd0;
      last_q      <= '0;
      addr_q      <= '0;
      csum_q      <= 8'd0;
      cnt_q       <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= 8'd0;
      core_hold_q <= 1'b1;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      err_code_q  <= 2'd0;
    end else begin
      state_q     <= state_d;
      len_lo_q    <= len_lo_d;
      last_q      <= last_d;
      addr_q      <= addr_d;
      csum_q      <= csum_d;
      cnt_q       <= cnt_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      core_hold_q <= core_hold_d;
      done_q      <= done_d;
      err_q       <= err_d;
      err_code_q  <= err_code_d;
    end
  end

  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign core_hold = core_hold_q;
  assign done      = done_q;
  assign err       = err_q;
  assign err_code  = err_code_q;
endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: table of frames plus hand-written corner sequences,
// with memory writes checked through an expected-write queue.
module tb_prog_loader;
  localparam int ADDR_W  = 12;
  localparam int TIMEOUT = 16;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              start = 1'b0;
  logic              in_valid = 1'b0;
  logic [7:0]        in_data = 8'd0;
  logic              in_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;
  logic              core_hold;
  logic              done;
  logic              err;
  logic [1:0]        err_code;

  prog_loader #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .core_hold(core_hold), .done(done), .err(err), .err_code(err_code)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [95:0] bytes;
    logic [3:0]  nb;
    logic [3:0]  pay_off;
    logic [3:0]  pay_n;
    logic        exp_done;
    logic        exp_err;
    logic [1:0]  exp_code;
  } vec_t;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [7:0]        data;
    int                cyc;
  } wr_t;

  wr_t  exp_q[$];
  vec_t vecs [5];
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_err = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Every write must match the oldest expected one, in the cycle right after its accept.
  always @(negedge clk) begin
    wr_t e;
    if (mem_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_write: addr %0h data %0h with none expected", mem_addr, mem_wdata);
      end else begin
        e = exp_q.pop_front();
        chk("wr_addr", 32'(mem_addr), 32'(e.addr));
        chk("wr_data", 32'(mem_wdata), 32'(e.data));
        chk("wr_cycle", cyc, e.cyc);
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input bit is_pay, input logic [ADDR_W-1:0] a);
    int w;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = b;
    w = 0;
    while (in_ready !== 1'b1 && w < 8) begin
      @(negedge clk);
      w++;
    end
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL byte_stall: byte %0h got in_ready %b expected 1", b, in_ready);
      in_valid = 1'b0;
    end else begin
      @(posedge clk);
      #1;
      if (is_pay) exp_q.push_back('{addr: a, data: b, cyc: cyc});
      in_valid = 1'b0;
    end
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_hold"}, 32'(core_hold), 32'd1);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_err"}, 32'(err), 32'd0);
    chk({tag, "_code"}, 32'(err_code), 32'd0);
    chk({tag, "_ready"}, 32'(in_ready), 32'd1);
    chk({tag, "_we"}, 32'(mem_we), 32'd0);
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    #1;
    check_idle("start");
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    bit p;
    pulse_start();
    for (int i = 0; i < int'(v.nb); i++) begin
      p = (i >= int'(v.pay_off)) && (i < int'(v.pay_off) + int'(v.pay_n));
      send_byte(v.bytes[95 - 8*i -: 8], p, ADDR_W'(i - int'(v.pay_off)));
    end
    repeat (2) @(negedge clk);
    chk($sformatf("v%0d_done", idx), 32'(done), 32'(v.exp_done));
    chk($sformatf("v%0d_err", idx), 32'(err), 32'(v.exp_err));
    chk($sformatf("v%0d_code", idx), 32'(err_code), 32'(v.exp_code));
    chk($sformatf("v%0d_hold", idx), 32'(core_hold), 32'(!v.exp_done));
    chk($sformatf("v%0d_ready", idx), 32'(in_ready), 32'd0);
    chk($sformatf("v%0d_pending_writes", idx), 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs[0] = '{bytes: {8'hA5, 8'h01, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h13, 32'h0},
                nb: 4'd8, pay_off: 4'd3, pay_n: 4'd4, exp_done: 1'b1, exp_err: 1'b0, exp_code: 2'd0};
    vecs[1] = '{bytes: {8'h00, 8'hFF, 8'h5A, 8'hA5, 8'h00, 8'h00, 8'h00, 40'h0},
                nb: 4'd7, pay_off: 4'd6, pay_n: 4'd0, exp_done: 1'b1, exp_err: 1'b0, exp_code: 2'd0};
    vecs[2] = '{bytes: {8'hA5, 8'h01, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'hFF, 32'h0},
                nb: 4'd8, pay_off: 4'd3, pay_n: 4'd4, exp_done: 1'b0, exp_err: 1'b1, exp_code: 2'd2};
    vecs[3] = '{bytes: {8'hA5, 8'h01, 8'h04, 72'h0},
                nb: 4'd3, pay_off: 4'd3, pay_n: 4'd0, exp_done: 1'b0, exp_err: 1'b1, exp_code: 2'd1};
    vecs[4] = '{bytes: {8'hA5, 8'h02, 8'h00, 8'h80, 8'h80, 8'h80, 8'h80, 8'h01, 8'h02, 8'h03, 8'h04, 8'h0A},
                nb: 4'd12, pay_off: 4'd3, pay_n: 4'd8, exp_done: 1'b1, exp_err: 1'b0, exp_code: 2'd0};

    repeat (3) @(posedge clk);
    #1;
    check_idle("reset");
    chk("reset_addr", 32'(mem_addr), 32'd0);
    chk("reset_wdata", 32'(mem_wdata), 32'd0);
    @(negedge clk);
    rst = 1'b1;

    for (int k = 0; k < 5; k++) run_vec(vecs[k], k);

    // After done, offered bytes must stall with no writes.
    run_vec(vecs[0], 10);
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 8'hA5;
    repeat (3) begin
      @(negedge clk);
      chk("done_stall_ready", 32'(in_ready), 32'd0);
    end
    in_valid = 1'b0;

    // A byte offered together with start is refused.
    @(negedge clk);
    start    = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'hA5;
    #1;
    chk("start_same_cycle_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    start    = 1'b0;
    in_valid = 1'b0;

    // start aborts a frame mid-DATA; the next frame loads from address 0.
    pulse_start();
    send_byte(8'hA5, 1'b0, '0);
    send_byte(8'h01, 1'b0, '0);
    send_byte(8'h00, 1'b0, '0);
    send_byte(8'h13, 1'b1, 12'd0);
    run_vec(vecs[0], 11);

    // Idle timeout: err must rise on exactly the 16th idle edge.
    pulse_start();
    send_byte(8'hA5, 1'b0, '0);
    send_byte(8'h01, 1'b0, '0);
    send_byte(8'h00, 1'b0, '0);
    send_byte(8'hAA, 1'b1, 12'd0);
    repeat (15) @(posedge clk);
    #1;
    chk("timeout_early_err", 32'(err), 32'd0);
    @(posedge clk);
    #1;
    chk("timeout_err", 32'(err), 32'd1);
    chk("timeout_code", 32'(err_code), 32'd3);
    chk("timeout_hold", 32'(core_hold), 32'd1);
    chk("timeout_ready", 32'(in_ready), 32'd0);
    chk("timeout_done", 32'(done), 32'd0);
    run_vec(vecs[0], 12);

    // Reset mid-DATA after two payload bytes.
    pulse_start();
    send_byte(8'hA5, 1'b0, '0);
    send_byte(8'h02, 1'b0, '0);
    send_byte(8'h00, 1'b0, '0);
    send_byte(8'h11, 1'b1, 12'd0);
    send_byte(8'h22, 1'b1, 12'd1);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check_idle("midreset");
    chk("midreset_addr", 32'(mem_addr), 32'd0);
    chk("midreset_wdata", 32'(mem_wdata), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    run_vec(vecs[0], 13);

    repeat (3) @(negedge clk);
    chk("final_pending_writes", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/prog_loader.md
Name: prog_loader

Overview:
- Upstream boot stage for the single-cycle core. Receives a framed byte stream (UART RX or host FIFO) over a valid/ready handshake.
- Writes the program byte-by-byte into the byte-wide instruction memory.
- Holds the core via core_hold until a complete frame with a valid checksum has been written.
- Gives the maths accelerator a way to load new programs without resynthesising the memory init file.

Parameters:
- ADDR_W, 12, instruction memory byte-address width; capacity is 2^ADDR_W bytes.
- TIMEOUT, 1000000, number of idle clk cycles allowed between bytes once a frame has started.

Ports:
- clk  input  1  clock
- rst  input  1  reset, synchronous, active-low
- start  input  1  one-cycle pulse; aborts any frame in progress and re-arms the loader
- in_valid  input  1  byte-stream valid
- in_data  input  8  byte-stream data
- in_ready  output  1  loader can accept a byte this cycle
- mem_we  output  1  instruction memory byte write enable
- mem_addr  output  ADDR_W  instruction memory byte address
- mem_wdata  output  8  instruction memory write data
- core_hold  output  1  high = keep the core in reset; low = core may run
- done  output  1  program loaded and verified (sticky)
- err  output  1  frame rejected (sticky)
- err_code  output  2  error cause: 0 none, 1 length too large, 2 checksum mismatch, 3 timeout

Behaviour:
- Accept is `in_valid && in_ready` at a posedge clk.
- Frame format:
  - sync byte 0xA5
  - LEN_LO, LEN_HI: 16-bit word count N
  - 4*N payload bytes, written in order starting at address 0
  - CSUM: sum of payload bytes mod 256
- States:
  - SYNC: in_ready=1; any byte other than 0xA5 is discarded. On 0xA5 go to LEN0.
  - LEN0: in_ready=1; latch the low byte; go to LEN1.
  - LEN1: in_ready=1; form N.
    - If N > 2^(ADDR_W-2): go to ERR with code 1.
    - If N == 0: go to CSUM.
    - Otherwise: clear the address counter and checksum; go to DATA.
  - DATA: in_ready=1; each accepted byte is written and added to the checksum, and the address increments. After byte 4*N-1 go to CSUM.
  - CSUM: in_ready=1.
    - If the received byte equals the running sum: go to DONE.
    - Otherwise: go to ERR with code 2.
  - DONE: in_ready=0, done=1, core_hold=0.
  - ERR: in_ready=0, err=1, core_hold=1.
- Reset (rst=0 at an edge) forces the following, even mid-frame:
  - state=SYNC, core_hold=1
  - done=0, err=0, err_code=0
  - mem_we=0, mem_addr=0, mem_wdata=0
  - address, checksum and timeout counters cleared
- Memory write timing: registered with 1-cycle latency. A byte accepted in DATA at edge k drives mem_we=1, mem_addr=A, mem_wdata=byte for the cycle after edge k. mem_we=0 in every other cycle.
- Address counter is ADDR_W bits. The maximum N fills the memory exactly: last address 2^ADDR_W-1. No wrap is possible because of the N check.
- Checksum is an 8-bit accumulator that wraps mod 256. The sync and length bytes are excluded.
- Timeout:
  - In LEN0, LEN1, DATA and CSUM, a counter increments each cycle without an accept and clears on every accept.
  - When the counter reaches TIMEOUT-1 with no accept that cycle, go to ERR with code 3.
  - The counter is inactive in SYNC, DONE and ERR.
- start pulse, from any state: go to SYNC, core_hold=1, done=0, err=0, err_code=0, counters cleared.
  - A byte presented in the same cycle as start is not accepted: in_ready=0 that cycle.
  - Memory contents are not cleared; stale bytes beyond the new program remain.
- Once in DONE or ERR, further bytes stall (in_ready=0) until start or reset.
- done and err are never high together.

Test Plan:
- Reset, then frame A5 01 00 13 00 00 00 13 → writes addr0..3 = 13,00,00,00 on consecutive cycles after each accept; done=1, core_hold=0, err_code=0.
- Garbage 00 FF 5A before the frame A5 00 00 00 → garbage ignored, no mem_we, done=1 after the CSUM byte 00.
- Frame A5 01 00 01 02 03 04 FF (correct checksum 0x0A) → all 4 bytes written, then err=1, err_code=2, core_hold=1, in_ready=0.
- A5 01 04 (N=1025 > 1024) → err_code=1 immediately after LEN_HI, no mem_we ever asserted.
- TIMEOUT=16: A5 01 00 AA then idle 16 cycles → err_code=3; a start pulse returns the loader to SYNC, and a subsequent valid frame completes with done=1.
- rst=0 asserted mid-DATA after 2 bytes → all outputs return to reset values; a new full frame loads correctly starting at addr 0.
